// File: rtl/fetch_unit_pkg.sv
// Shared widths and payload types for the fetch stage.
// Lane count and fetch-queue depth are fixed here; every width derives from them.
package fetch_unit_pkg;

    localparam int unsigned N       = 2;                    // superscalar width
    localparam int unsigned FQ_SIZE = 8;                    // power of 2, >= N
    localparam int unsigned IDX_W   = $clog2(FQ_SIZE);      // head/tail pointer width
    localparam int unsigned CNT_W   = $clog2(FQ_SIZE) + 1;  // occupancy 0..FQ_SIZE
    localparam int unsigned DEQ_W   = $clog2(N + 1);        // dequeue count 0..N
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INST_W  = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    // Predictor output for one lane: that lane's next PC.
    typedef struct packed {
        addr_t pc;
        logic  taken;
        logic  valid;
    } pc_entry_t;

    // One fetch-queue slot.
    typedef struct packed {
        logic  valid;
        inst_t inst;
        addr_t pc;
        addr_t npc;
        logic  taken;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: up to N enqueues and N dequeues per cycle.
// Ports:
//   clock, reset      sync active-high reset of head/tail/count
//   flush             empties the queue (pointers only), blocks enqueue/dequeue
//   enq_num           number of leading enq_entries to write at tail
//   enq_entries       N candidate entries, lane 0 first
//   deq_num           entries consumed by dispatch (clamped to count)
//   head_entries      oldest N entries, valid = (i < count)
//   count             current occupancy
//   debug_q/head/tail raw storage and pointers (CPU_DEBUG_OUT only)
module fetch_queue
    import fetch_unit_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [CNT_W-1:0]      enq_num,
    input  fq_entry_t [N-1:0]     enq_entries,
    input  logic [DEQ_W-1:0]      deq_num,
`ifdef CPU_DEBUG_OUT
    output fq_entry_t             debug_q [FQ_SIZE],
    output logic [IDX_W-1:0]      debug_head,
    output logic [IDX_W-1:0]      debug_tail,
`endif
    output fq_entry_t [N-1:0]     head_entries,
    output logic [CNT_W-1:0]      count
);

    fq_entry_t        q [FQ_SIZE];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CNT_W-1:0] deq_eff;

    // Dequeue is taken against the pre-enqueue occupancy.
    assign deq_eff = (CNT_W'(deq_num) > count) ? count : CNT_W'(deq_num);

    // Pointer/occupancy update; pointers wrap naturally, count separates full from empty.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + IDX_W'(deq_eff);
            tail  <= tail + IDX_W'(enq_num);
            count <= count - deq_eff + enq_num;
        end
    end

    // Storage write; contents are not cleared on reset or flush.
    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            for (int i = 0; i < int'(N); i++) begin
                if (CNT_W'(i) < enq_num) begin
                    q[tail + IDX_W'(i)] <= enq_entries[i];
                end
            end
        end
    end

    // Head window; valid comes from occupancy, not from the stored bit.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            head_entries[i]       = q[head + IDX_W'(i)];
            head_entries[i].valid = (CNT_W'(i) < count);
        end
    end

    // Dispatch must never ask for more than is queued.
    deq_overrun_a: assert property (@(posedge clock) disable iff (reset || flush)
                                    CNT_W'(deq_num) <= count)
        else $error("fetch_queue: deq_num %0d exceeds count %0d", deq_num, count);

`ifdef CPU_DEBUG_OUT
    assign debug_q    = q;
    assign debug_head = head;
    assign debug_tail = tail;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the fetch PC, chains predictor targets into
// per-lane I-cache addresses, enqueues the leading run of hits and exposes
// the oldest N queued instructions to dispatch.
// Ports:
//   clock, reset   sync active-high reset
//   squash         flush queue and redirect to squash_pc (priority below reset)
//   squash_pc      redirect target
//   pc_start       current fetch PC to the predictor
//   target_pc      per-lane predicted next PC / taken
//   icache_addr    per-lane lookup address (comb)
//   icache_hit     per-lane hit, same cycle
//   icache_inst    per-lane instruction word
//   fq_entries     oldest N queue entries, entry 0 = head
//   fq_count       queue occupancy
//   deq_num        entries taken by dispatch this cycle
//   fq_debug_*     queue storage and pointers (CPU_DEBUG_OUT only)
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  addr_t                 squash_pc,
    output addr_t                 pc_start,
    input  pc_entry_t [N-1:0]     target_pc,
    output addr_t [N-1:0]         icache_addr,
    input  logic [N-1:0]          icache_hit,
    input  inst_t [N-1:0]         icache_inst,
`ifdef CPU_DEBUG_OUT
    output fq_entry_t             fq_debug_q [FQ_SIZE],
    output logic [IDX_W-1:0]      fq_debug_head,
    output logic [IDX_W-1:0]      fq_debug_tail,
`endif
    output fq_entry_t [N-1:0]     fq_entries,
    output logic [CNT_W-1:0]      fq_count,
    input  logic [DEQ_W-1:0]      deq_num
);

    addr_t             pc_q;
    addr_t             next_pc;
    logic [CNT_W-1:0]  hit_run;
    logic [CNT_W-1:0]  free_slots;
    logic [CNT_W-1:0]  enq_k;
    logic              blocked;
    fq_entry_t [N-1:0] enq_entries;
    logic              unused_target_valid;

    assign pc_start = pc_q;

    // Lane 0 looks up the fetch PC; later lanes follow the predicted chain.
    always_comb begin
        icache_addr[0] = pc_q;
        for (int i = 1; i < int'(N); i++) begin
            icache_addr[i] = target_pc[i-1].pc;
        end
    end

    // Leading contiguous hits from lane 0; the first miss blocks all later lanes.
    always_comb begin
        hit_run = '0;
        blocked = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!icache_hit[i]) begin
                blocked = 1'b1;
            end
            if (!blocked) begin
                hit_run = hit_run + CNT_W'(1);
            end
        end
    end

    // Free space uses registered occupancy only; same-cycle dequeue does not help.
    assign free_slots = CNT_W'(FQ_SIZE) - fq_count;
    assign enq_k      = squash ? '0 : ((hit_run < free_slots) ? hit_run : free_slots);

    // Candidate entries and the PC following the last enqueued lane.
    always_comb begin
        next_pc = pc_q;
        for (int i = 0; i < int'(N); i++) begin
            enq_entries[i].valid = 1'b1;
            enq_entries[i].inst  = icache_inst[i];
            enq_entries[i].pc    = icache_addr[i];
            enq_entries[i].npc   = target_pc[i].pc;
            enq_entries[i].taken = target_pc[i].taken;
            if (enq_k == CNT_W'(i + 1)) begin
                next_pc = target_pc[i].pc;
            end
        end
    end

    // Predictor lane-valid is not consumed: the hit run alone gates enqueue.
    always_comb begin
        unused_target_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            unused_target_valid = unused_target_valid ^ target_pc[i].valid;
        end
    end

    // Fetch PC: reset > squash redirect > advance past enqueued lanes > hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= '0;
        end else if (squash) begin
            pc_q <= squash_pc;
        end else if (enq_k != '0) begin
            pc_q <= next_pc;
        end
    end

    fetch_queue u_fetch_queue (
        .clock        (clock),
        .reset        (reset),
        .flush        (squash),
        .enq_num      (enq_k),
        .enq_entries  (enq_entries),
        .deq_num      (deq_num),
`ifdef CPU_DEBUG_OUT
        .debug_q      (fq_debug_q),
        .debug_head   (fq_debug_head),
        .debug_tail   (fq_debug_tail),
`endif
        .head_entries (fq_entries),
        .count        (fq_count)
    );

endmodule
